// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle sequencer for an RV32 R-type datapath: byte-serial fetch,
// R-type validation, then DECODE/EXEC/WB control of the register file and ALU.
module rtype_seq_ctrl #(
  parameter int IMEM_AW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [IMEM_AW-1:0]   imem_addr,
  input  logic [7:0]           imem_rdata,
  output logic [31:0]          instr,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  output logic [4:0]           rd_addr,
  output logic [3:0]           alu_op,
  output logic                 rf_we,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic [IMEM_AW-2:0]   instr_count
);

  localparam int CW = IMEM_AW - 1;
  localparam logic [IMEM_AW-1:0] ADDR_ONE = IMEM_AW'(1);
  localparam logic [IMEM_AW-1:0] PC_STEP  = IMEM_AW'(4);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [6:0]         OP_RTYPE = 7'b0110011;
  localparam logic [6:0]         F7_BASE  = 7'b0000000;
  localparam logic [6:0]         F7_ALT   = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IMEM_AW-1:0]  pc_q, pc_d;
  logic [IMEM_AW-1:0]  addr_q, addr_d;
  logic [2:0]          k_q, k_d;
  logic [31:0]         instr_q, instr_d;
  logic [4:0]          rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic                illegal_q, illegal_d;
  logic [CW-1:0]       count_q, count_d;
  logic [IMEM_AW-1:0]  pc_inc;

  // NOTE: every signal written here gets its default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    k_d       = k_q;
    instr_d   = instr_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    alu_op_d  = alu_op_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    pc_inc    = pc_q + PC_STEP;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          addr_d    = '0;
          k_d       = 3'd0;
          count_d   = '0;
          illegal_d = 1'b0;
        end
      end
      S_FETCH: begin
        // Bytes arrive one cycle behind the address, lowest address first,
        // so shifting left leaves the first byte in instr[31:24].
        if (k_q != 3'd0) instr_d = {instr_q[23:0], imem_rdata};
        if (k_q < 3'd3)  addr_d  = addr_q + ADDR_ONE;
        if (k_q == 3'd4) begin
          state_d = S_DECODE;
          k_d     = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_DECODE: begin
        rs1_d    = instr_q[19:15];
        rs2_d    = instr_q[24:20];
        rd_d     = instr_q[11:7];
        alu_op_d = {instr_q[30], instr_q[14:12]};
        if (instr_q == 32'h0) begin
          state_d = S_DONE;
        end else if (instr_q[6:0] != OP_RTYPE) begin
          illegal_d = 1'b1;
          state_d   = S_DONE;
        end else if (instr_q[31:25] != F7_BASE && instr_q[31:25] != F7_ALT) begin
          illegal_d = 1'b1;
          state_d   = S_DONE;
        end else if (instr_q[31:25] == F7_ALT &&
                     instr_q[14:12] != 3'b000 && instr_q[14:12] != 3'b101) begin
          illegal_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (count_q != '1) count_d = count_q + CNT_ONE;
        pc_d    = pc_inc;
        addr_d  = pc_inc;
        k_d     = 3'd0;
        // A wrapped pc means the last word in memory has just retired.
        state_d = (pc_inc == '0) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers; the reset clears all of them, including
  // the held decode fields, so outputs are defined straight out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      addr_q    <= '0;
      k_q       <= 3'd0;
      instr_q   <= 32'h0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      alu_op_q  <= 4'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      k_q       <= k_d;
      instr_q   <= instr_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign rs1_addr    = rs1_q;
  assign rs2_addr    = rs2_q;
  assign rd_addr     = rd_q;
  assign alu_op      = alu_op_q;
  assign rf_we       = (state_q == S_WB) && (rd_q != 5'd0);
  assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXEC)  || (state_q == S_WB);
  assign done        = (state_q == S_DONE);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Scoreboard bench for rtype_seq_ctrl: two instances (IMEM_AW=5 and 3), each
// fed by a synchronous-read byte memory.
module tb_rtype_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start5, start3;
  logic [4:0]  addr5;
  logic [2:0]  addr3;
  logic [7:0]  rdata5, rdata3;
  logic [31:0] instr5, instr3;
  logic [4:0]  rs1_5, rs2_5, rd5, rs1_3, rs2_3, rd3;
  logic [3:0]  alu5, alu3;
  logic        we5, busy5, done5, ill5, we3, busy3, done3, ill3;
  logic [3:0]  cnt5;
  logic [1:0]  cnt3;

  logic [7:0] mem5 [32];
  logic [7:0] mem3 [8];
  always @(posedge clk) rdata5 <= mem5[addr5];
  always @(posedge clk) rdata3 <= mem3[addr3];

  rtype_seq_ctrl #(.IMEM_AW(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start5), .imem_addr(addr5),
    .imem_rdata(rdata5), .instr(instr5), .rs1_addr(rs1_5), .rs2_addr(rs2_5),
    .rd_addr(rd5), .alu_op(alu5), .rf_we(we5), .busy(busy5), .done(done5),
    .illegal(ill5), .instr_count(cnt5));

  rtype_seq_ctrl #(.IMEM_AW(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .imem_addr(addr3),
    .imem_rdata(rdata3), .instr(instr3), .rs1_addr(rs1_3), .rs2_addr(rs2_3),
    .rd_addr(rd3), .alu_op(alu3), .rf_we(we3), .busy(busy3), .done(done3),
    .illegal(ill3), .instr_count(cnt3));

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
  } wr_t;

  typedef struct {
    int   cnt;
    logic ill;
    int   lat;
  } dn_t;

  wr_t wq5[$], wq3[$];
  dn_t dq5[$], dq3[$];
  int  we_cyc5[$];
  int  t0_5 = 0;
  int  t0_3 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write and end-of-program monitors pop the scoreboards as events appear.
  always @(negedge clk) begin
    if (we5) begin
      we_cyc5.push_back(cyc);
      check("wr5_pending", wq5.size() > 0, 1);
      if (wq5.size() > 0) begin
        wr_t e;
        e = wq5.pop_front();
        check("wr5_instr", instr5, e.instr);
        check("wr5_rs1", rs1_5, e.rs1);
        check("wr5_rs2", rs2_5, e.rs2);
        check("wr5_rd", rd5, e.rd);
        check("wr5_alu", alu5, e.alu);
      end
    end
    if (done5) begin
      check("dn5_pending", dq5.size() > 0, 1);
      if (dq5.size() > 0) begin
        dn_t e;
        e = dq5.pop_front();
        check("dn5_busy", busy5, 0);
        check("dn5_count", cnt5, e.cnt);
        check("dn5_illegal", ill5, e.ill);
        check("dn5_latency", cyc - t0_5 + 1, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (we3) begin
      check("wr3_pending", wq3.size() > 0, 1);
      if (wq3.size() > 0) begin
        wr_t e;
        e = wq3.pop_front();
        check("wr3_instr", instr3, e.instr);
        check("wr3_rd", rd3, e.rd);
        check("wr3_alu", alu3, e.alu);
      end
    end
    if (done3) begin
      check("dn3_pending", dq3.size() > 0, 1);
      if (dq3.size() > 0) begin
        dn_t e;
        e = dq3.pop_front();
        check("dn3_count", cnt3, e.cnt);
        check("dn3_illegal", ill3, e.ill);
        check("dn3_latency", cyc - t0_3 + 1, e.lat);
      end
    end
  end

  task automatic clear5();
    foreach (mem5[i]) mem5[i] = 8'h00;
  endtask

  task automatic put5(input int i, input logic [31:0] w);
    mem5[4*i]   = w[31:24];
    mem5[4*i+1] = w[23:16];
    mem5[4*i+2] = w[15:8];
    mem5[4*i+3] = w[7:0];
  endtask

  task automatic put3(input int i, input logic [31:0] w);
    mem3[4*i]   = w[31:24];
    mem3[4*i+1] = w[23:16];
    mem3[4*i+2] = w[15:8];
    mem3[4*i+3] = w[7:0];
  endtask

  task automatic push_wr5(input logic [31:0] w, input int rs1, input int rs2,
                          input int rd, input logic [3:0] alu);
    wr_t e;
    e.instr = w; e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.rd = 5'(rd); e.alu = alu;
    wq5.push_back(e);
  endtask

  task automatic push_dn5(input int cnt, input logic ill, input int lat);
    dn_t e;
    e.cnt = cnt; e.ill = ill; e.lat = lat;
    dq5.push_back(e);
  endtask

  // Returns #1 after the edge that accepted start (first FETCH cycle).
  task automatic go5();
    @(posedge clk); #1 start5 = 1'b1;
    @(posedge clk); #1 t0_5 = cyc; start5 = 1'b0;
  endtask

  task automatic go3();
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 t0_3 = cyc; start3 = 1'b0;
  endtask

  task automatic wait5(input int budget);
    int n = 0;
    while (dq5.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("dn5_timeout", dq5.size(), 0);
    check("wr5_left", wq5.size(), 0);
    dq5.delete();
    wq5.delete();
  endtask

  task automatic wait3(input int budget);
    int n = 0;
    while (dq3.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("dn3_timeout", dq3.size(), 0);
    check("wr3_left", wq3.size(), 0);
    dq3.delete();
    wq3.delete();
  endtask

  task automatic check_reset5(input string tag);
    check({tag, "_instr"}, instr5, 0);
    check({tag, "_addr"}, addr5, 0);
    check({tag, "_rfwe"}, we5, 0);
    check({tag, "_busy"}, busy5, 0);
    check({tag, "_done"}, done5, 0);
    check({tag, "_ill"}, ill5, 0);
    check({tag, "_cnt"}, cnt5, 0);
    check({tag, "_alu"}, alu5, 0);
    check({tag, "_fields"}, {rs1_5, rs2_5, rd5}, 0);
  endtask

  initial begin
    start5 = 1'b0;
    start3 = 1'b0;
    clear5();
    foreach (mem3[i]) mem3[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1 check_reset5("rst");
    check("rst3_busy", busy3, 0);
    reset = 1'b1;

    // 1: add x9,x6,x5 ; sub x10,x6,x5 ; zero word ends the program
    clear5();
    put5(0, 32'h005304B3);
    put5(1, 32'h40530533);
    push_wr5(32'h005304B3, 6, 5, 9, 4'b0000);
    push_wr5(32'h40530533, 6, 5, 10, 4'b1000);
    push_dn5(2, 1'b0, 23);
    we_cyc5.delete();
    go5();
    check("t1_first_addr", addr5, 0);
    wait5(100);
    check("t1_we_pulses", we_cyc5.size(), 2);
    if (we_cyc5.size() >= 2) check("t1_we_gap", we_cyc5[1] - we_cyc5[0], 8);

    // 2: add x0,x0,x0 retires without a write
    clear5();
    put5(0, 32'h00000033);
    push_dn5(1, 1'b0, 15);
    go5();
    wait5(100);

    // 3: ADDI opcode is illegal; flag is sticky while idle
    clear5();
    put5(0, 32'h00000013);
    push_dn5(0, 1'b1, 7);
    go5();
    wait5(100);
    repeat (5) @(posedge clk);
    #1 check("t3_ill_sticky", ill5, 1);

    // 4a: funct7=0100000 with funct3=001 is illegal; start clears old flag
    clear5();
    put5(0, 32'h40531533);
    push_dn5(0, 1'b1, 7);
    go5();
    check("t4_ill_cleared", ill5, 0);
    wait5(100);

    // 4b: sra x10,x6,x5 is legal
    clear5();
    put5(0, 32'h40535533);
    push_wr5(32'h40535533, 6, 5, 10, 4'b1101);
    push_dn5(1, 1'b0, 15);
    go5();
    wait5(100);

    // 5: IMEM_AW=3 holds two words; pc wrap ends the program
    put3(0, 32'h005304B3);
    put3(1, 32'h40530533);
    begin
      wr_t w;
      dn_t d;
      w.instr = 32'h005304B3; w.rs1 = 5'd6; w.rs2 = 5'd5; w.rd = 5'd9;  w.alu = 4'b0000;
      wq3.push_back(w);
      w.instr = 32'h40530533; w.rd = 5'd10; w.alu = 4'b1000;
      wq3.push_back(w);
      d.cnt = 2; d.ill = 1'b0; d.lat = 17;
      dq3.push_back(d);
    end
    go3();
    wait3(100);

    // 6: reset during fetch byte 2, restart, stray start while busy
    clear5();
    put5(0, 32'h005304B3);
    put5(1, 32'h40530533);
    go5();
    @(posedge clk); #1;
    @(posedge clk); #1 check("t6_pre_busy", busy5, 1);
    reset = 1'b0;
    @(posedge clk); #1 check_reset5("t6_rst");
    reset = 1'b1;
    push_wr5(32'h005304B3, 6, 5, 9, 4'b0000);
    push_wr5(32'h40530533, 6, 5, 10, 4'b1000);
    push_dn5(2, 1'b0, 23);
    go5();
    check("t6_addr0", addr5, 0);
    check("t6_busy", busy5, 1);
    @(posedge clk); #1 check("t6_addr1", addr5, 1);
    repeat (4) @(posedge clk);
    #1 start5 = 1'b1;
    @(posedge clk); #1 start5 = 1'b0;
    wait5(100);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
